// File: rtl/addsub_nibble_seq_if.sv
// Operand/result handshake bundle between the ALU operand registers and the nibble-serial add/sub controller.
interface addsub_nibble_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, c_out, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, c_out, ovf
  );
endinterface

// File: rtl/addsub_nibble_seq.sv
// Nibble-serial signed add/subtract controller: drives one shared 4-bit add/sub block, LSB nibble first,
// chaining the carry register between nibbles.
//
//   state   | meaning
//   IDLE    | waiting for start; result/c_out/ovf hold the last operation
//   RUN     | one nibble per cycle, r_idx = 0..NIB-1
//   DONE    | one-cycle done pulse, outputs valid
module addsub_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  addsub_nibble_seq_if.slave  bus,
  output logic                o_as_op,
  output logic [3:0]          o_as_a,
  output logic [3:0]          o_as_b,
  output logic                o_as_cin,
  input  logic [3:0]          i_as_sum,
  input  logic                i_as_cout
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = $clog2(NIB);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDXW-1:0]  r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_c_out;
  logic             r_ovf;

  logic             w_run;
  logic             w_last;
  logic             w_accept;
  logic [3:0]       w_nib_a;
  logic [3:0]       w_nib_b;
  logic             w_beff_msb;

  assign w_run      = (r_state == ST_RUN);
  assign w_last     = w_run && (r_idx == LAST_IDX);
  assign w_accept   = (r_state == ST_IDLE) && bus.start;
  assign w_beff_msb = r_op ? ~r_b[WIDTH-1] : r_b[WIDTH-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE:                w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Nibble select from the captured operands; a loop keeps the index decode free of variable part-selects.
  always_comb begin
    w_nib_a = 4'h0;
    w_nib_b = 4'h0;
    for (int n = 0; n < NIB; n++) begin
      if (r_idx == n[IDXW-1:0]) begin
        w_nib_a = r_a[4*n +: 4];
        w_nib_b = r_b[4*n +: 4];
      end
    end
  end

  assign o_as_op  = w_run & r_op;
  assign o_as_a   = w_run ? w_nib_a : 4'h0;
  assign o_as_b   = w_run ? w_nib_b : 4'h0;
  assign o_as_cin = w_run & r_carry;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_result <= '0;
      r_c_out  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_op    <= bus.op;
      r_idx   <= '0;
      r_carry <= bus.op;
    end else if (w_run) begin
      for (int n = 0; n < NIB; n++) begin
        if (r_idx == n[IDXW-1:0]) begin
          r_result[4*n +: 4] <= i_as_sum;
        end
      end
      r_carry <= i_as_cout;
      if (w_last) begin
        r_c_out <= i_as_cout;
        // Signed overflow: operands agree in sign but the MSB nibble's sum bit disagrees.
        r_ovf   <= (r_a[WIDTH-1] == w_beff_msb) && (i_as_sum[3] != r_a[WIDTH-1]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.done   = (r_state == ST_DONE);
  assign bus.result = r_result;
  assign bus.c_out  = r_c_out;
  assign bus.ovf    = r_ovf;

endmodule
